// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level I2C sequencer on top of a bit-level PHY.
// Runs START / 8-bit WRITE+ACK or READ+ACK / STOP as a chain of PHY bit ops.
//
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_start/stop/write/read command phases, cmd_ack = ACK bit sent after a read
//   tx_byte                   byte to write
//   rx_byte, rx_ack           last read byte / ACK sampled after a write
//   done, err                 one-cycle completion / error pulses
//   busy                      command in progress
//   phy_*_bit, phy_release_bus one-cycle PHY command pulses
//   phy_tx_data               bit to write, stable for the whole bit op
//   phy_busy, phy_rx_data_reg, bus_control_reg  PHY status
module i2c_byte_ctrl #(
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_ack,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_ack,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic       phy_start_bit,
    output logic       phy_stop_bit,
    output logic       phy_write_bit,
    output logic       phy_read_bit,
    output logic       phy_release_bus,
    output logic       phy_tx_data,
    input  logic       phy_busy,
    input  logic       phy_rx_data_reg,
    input  logic       bus_control_reg
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK,
        S_STOP,
        S_DONE,
        S_ABORT
    } state_t;

    typedef enum logic [1:0] {
        P_ISSUE,
        P_WAIT_HI,
        P_WAIT_LO
    } phase_t;

    // Timer counts 0..BUSY_TIMEOUT-1; the last value aborts on the next wait.
    localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rxb_q, rxb_d;
    logic          rxa_q, rxa_d;
    logic          c_stop_q, c_stop_d;
    logic          c_write_q, c_write_d;
    logic          c_read_q, c_read_d;
    logic          c_ack_q, c_ack_d;
    logic          rej_q, rej_d;
    logic          issue_ok;
    logic          wait_c;
    logic          complete;

    // Phase that follows START (or acceptance when no START is asked for).
    function automatic state_t after_start(input logic w, input logic r,
                                           input logic p);
        state_t s;
        if (w) begin
            s = S_WRITE;
        end else if (r) begin
            s = S_READ;
        end else if (p) begin
            s = S_STOP;
        end else begin
            s = S_DONE;
        end
        return s;
    endfunction

    function automatic state_t after_ack(input logic p);
        return p ? S_STOP : S_DONE;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            phase_q   <= P_ISSUE;
            cnt_q     <= 3'd0;
            tmo_q     <= '0;
            tx_q      <= 8'h00;
            rxb_q     <= 8'h00;
            rxa_q     <= 1'b1;
            c_stop_q  <= 1'b0;
            c_write_q <= 1'b0;
            c_read_q  <= 1'b0;
            c_ack_q   <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            tx_q      <= tx_d;
            rxb_q     <= rxb_d;
            rxa_q     <= rxa_d;
            c_stop_q  <= c_stop_d;
            c_write_q <= c_write_d;
            c_read_q  <= c_read_d;
            c_ack_q   <= c_ack_d;
            rej_q     <= rej_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        tx_d      = tx_q;
        rxb_d     = rxb_q;
        rxa_d     = rxa_q;
        c_stop_d  = c_stop_q;
        c_write_d = c_write_q;
        c_read_d  = c_read_q;
        c_ack_d   = c_ack_q;
        rej_d     = 1'b0;
        issue_ok  = 1'b0;
        wait_c    = 1'b0;
        complete  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write && cmd_read) begin
                        rej_d = 1'b1;
                    end else begin
                        c_stop_d  = cmd_stop;
                        c_write_d = cmd_write;
                        c_read_d  = cmd_read;
                        c_ack_d   = cmd_ack;
                        tx_d      = tx_byte;
                        cnt_d     = 3'd7;
                        tmo_d     = '0;
                        phase_d   = P_ISSUE;
                        state_d   = cmd_start ? S_START
                                  : after_start(cmd_write, cmd_read,
                                                cmd_stop);
                    end
                end
            end

            S_DONE, S_ABORT: begin
                state_d = S_IDLE;
                phase_d = P_ISSUE;
            end

            default: begin
                unique case (phase_q)
                    P_ISSUE: begin
                        if (!phy_busy) begin
                            issue_ok = 1'b1;
                            phase_d  = P_WAIT_HI;
                            tmo_d    = '0;
                        end else begin
                            wait_c = 1'b1;
                        end
                    end
                    P_WAIT_HI: begin
                        if (phy_busy) begin
                            phase_d = P_WAIT_LO;
                        end else begin
                            wait_c = 1'b1;
                        end
                    end
                    P_WAIT_LO: begin
                        if (phy_busy) begin
                            wait_c = 1'b1;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    default: phase_d = P_ISSUE;
                endcase

                if (wait_c) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_ABORT;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end

                if (complete) begin
                    phase_d = P_ISSUE;
                    tmo_d   = '0;
                    // Losing the bus mid-transfer is fatal; START
                    // is the op that acquires it, so it is exempt.
                    if (state_q != S_START && !bus_control_reg) begin
                        state_d = S_ABORT;
                    end else begin
                        unique case (state_q)
                            S_START: begin
                                state_d = after_start(c_write_q, c_read_q,
                                                      c_stop_q);
                            end
                            S_WRITE: begin
                                tx_d  = {tx_q[6:0], 1'b0};
                                cnt_d = cnt_q - 3'd1;
                                if (cnt_q == 3'd0) begin
                                    state_d = S_WRITE_ACK;
                                end
                            end
                            S_WRITE_ACK: begin
                                rxa_d   = phy_rx_data_reg;
                                state_d = after_ack(c_stop_q);
                            end
                            S_READ: begin
                                rxb_d = {rxb_q[6:0], phy_rx_data_reg};
                                cnt_d = cnt_q - 3'd1;
                                if (cnt_q == 3'd0) begin
                                    state_d = S_READ_ACK;
                                end
                            end
                            S_READ_ACK: begin
                                state_d = after_ack(c_stop_q);
                            end
                            S_STOP: begin
                                state_d = S_DONE;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = rej_q | (state_q == S_ABORT);
    assign rx_byte   = rxb_q;
    assign rx_ack    = rxa_q;

    assign phy_start_bit   = issue_ok & (state_q == S_START);
    assign phy_stop_bit    = issue_ok & (state_q == S_STOP);
    assign phy_write_bit   = issue_ok & ((state_q == S_WRITE) |
                                         (state_q == S_READ_ACK));
    assign phy_read_bit    = issue_ok & ((state_q == S_READ) |
                                         (state_q == S_WRITE_ACK));
    assign phy_release_bus = (state_q == S_ABORT);

    // Driven from registered state so it stays put until the op completes.
    assign phy_tx_data = (state_q == S_WRITE)    ? tx_q[7]
                       : (state_q == S_READ_ACK) ? c_ack_q
                       : 1'b0;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: randomized self-checking bench for i2c_byte_ctrl.
// A behavioural PHY logs bit ops; expected op lists come from the command.
module tb_i2c_byte_ctrl;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic       cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack;
    logic [7:0] tx_byte, rx_byte;
    logic       rx_ack, done, err, busy;
    logic       phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit;
    logic       phy_release_bus, phy_tx_data;
    logic       phy_busy, phy_rx_data_reg, bus_control_reg;

    i2c_byte_ctrl #(.BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_write(cmd_write), .cmd_read(cmd_read), .cmd_ack(cmd_ack),
        .tx_byte(tx_byte), .rx_byte(rx_byte), .rx_ack(rx_ack),
        .done(done), .err(err), .busy(busy),
        .phy_start_bit(phy_start_bit), .phy_stop_bit(phy_stop_bit),
        .phy_write_bit(phy_write_bit), .phy_read_bit(phy_read_bit),
        .phy_release_bus(phy_release_bus), .phy_tx_data(phy_tx_data),
        .phy_busy(phy_busy), .phy_rx_data_reg(phy_rx_data_reg),
        .bus_control_reg(bus_control_reg)
    );

    always #5 clk = ~clk;

    // Op codes: 10 START, 11 STOP, 20/21 WRITE bit 0/1, 30 READ.
    int log_q[$];
    int exp_q[$];
    bit rx_src[$];
    int n_pulse, n_rel, n_done, n_err, n_wr, n_rd;
    int n_multi, n_unstable;
    int cyc_g, first_wr_cyc, err_cyc;
    int mphase, mhold, mraise;
    bit mread, mtx, stuck_first_wr, stuck_now, drop_now;
    int drop_at;
    int n_chk, n_pass;
    logic [7:0] exp_rxb;
    logic       exp_ack;

    // Behavioural PHY plus monitor, evaluated on every falling edge.
    initial begin : phy_model
        int npl;
        forever begin
            @(negedge clk);
            cyc_g++;
            npl = int'(phy_start_bit) + int'(phy_stop_bit) +
                  int'(phy_write_bit) + int'(phy_read_bit) +
                  int'(phy_release_bus);
            if (npl > 1) n_multi++;
            n_pulse += npl;
            if (phy_release_bus) n_rel++;
            if (done) n_done++;
            if (err) begin
                n_err++;
                if (err_cyc < 0) err_cyc = cyc_g;
            end
            if (mphase != 0 && busy && !err && mtx != phy_tx_data)
                n_unstable++;
            if (mphase == 0 && npl > 0 && !phy_release_bus) begin
                mread = phy_read_bit;
                mtx = phy_tx_data;
                if (phy_start_bit) log_q.push_back(10);
                else if (phy_stop_bit) log_q.push_back(11);
                else if (phy_write_bit) begin
                    log_q.push_back(20 + int'(phy_tx_data));
                    n_wr++;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc_g;
                end else begin
                    log_q.push_back(30);
                    n_rd++;
                end
                drop_now = phy_write_bit && (n_wr == drop_at);
                stuck_now = phy_write_bit && stuck_first_wr;
                mraise = int'($urandom_range(0, 2));
                mphase = 1;
            end else if (mphase == 1) begin
                if (mraise > 0) mraise--;
                else begin
                    phy_busy = 1'b1;
                    mphase = 2;
                    mhold = int'($urandom_range(0, 3));
                    if (mread)
                        phy_rx_data_reg = (rx_src.size() > 0)
                                        ? rx_src.pop_front() : 1'b1;
                    if (drop_now) bus_control_reg = 1'b0;
                end
            end else if (mphase == 2 && !stuck_now) begin
                if (mhold > 0) mhold--;
                else begin
                    phy_busy = 1'b0;
                    mphase = 0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_idle();
        phy_busy = 1'b0;
        mphase = 0;
        stuck_now = 1'b0;
        drop_now = 1'b0;
    endtask

    task automatic clear_mon();
        log_q.delete();
        rx_src.delete();
        n_pulse = 0; n_rel = 0; n_done = 0; n_err = 0;
        n_wr = 0; n_rd = 0;
        err_cyc = -1; first_wr_cyc = -1;
    endtask

    // Expected PHY op list straight from the command fields.
    function automatic void build_exp(bit s, bit p, bit w, bit r, bit a,
                                      logic [7:0] tx);
        exp_q.delete();
        if (s) exp_q.push_back(10);
        if (w) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(20 + int'(tx[i]));
            exp_q.push_back(30);
        end
        if (r) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(30);
            exp_q.push_back(20 + int'(a));
        end
        if (p) exp_q.push_back(11);
    endfunction

    function automatic int first_diff();
        int n;
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (log_q[i] != exp_q[i]) return i;
        if (log_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic run_cmd(input bit s, input bit p, input bit w,
                           input bit r, input bit a, input logic [7:0] tx,
                           input logic [7:0] rb, input bit ackr);
        int wc;
        clear_mon();
        if (w) rx_src.push_back(ackr);
        if (r) for (int i = 7; i >= 0; i--) rx_src.push_back(rb[i]);
        cmd_valid = 1'b1;
        cmd_start = s; cmd_stop = p; cmd_write = w; cmd_read = r;
        cmd_ack = a; tx_byte = tx;
        tick();
        cmd_valid = 1'b0;
        tx_byte = 8'($urandom);
        cmd_start = 1'($urandom); cmd_stop = 1'($urandom);
        cmd_ack = 1'($urandom);
        cmd_write = 1'($urandom); cmd_read = 1'($urandom);
        wc = 0;
        while (n_done == 0 && n_err == 0 && wc < 500) begin
            tick();
            wc++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        cmd_write = 1'b0; cmd_read = 1'b0; cmd_ack = 1'b0;
        tx_byte = 8'h00;
        phy_rx_data_reg = 1'b0; bus_control_reg = 1'b1;
        model_idle();
        stuck_first_wr = 1'b0; drop_at = 0;
        tick(); tick(); tick();
        n_chk++;
        if ({cmd_ready, busy, done, err} !== 4'b1000)
            $display("FAIL reset_ctrl got %b want 1000",
                     {cmd_ready, busy, done, err});
        else n_pass++;
        n_chk++;
        if (rx_byte !== 8'h00)
            $display("FAIL reset_rx_byte got %h want 00", rx_byte);
        else n_pass++;
        n_chk++;
        if (rx_ack !== 1'b1)
            $display("FAIL reset_rx_ack got %b want 1", rx_ack);
        else n_pass++;
        n_chk++;
        if ({phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit,
             phy_release_bus, phy_tx_data} !== 6'b0)
            $display("FAIL reset_phy got %b want 000000",
                     {phy_start_bit, phy_stop_bit, phy_write_bit,
                      phy_read_bit, phy_release_bus, phy_tx_data});
        else n_pass++;
        rst = 1'b1;
        tick();
        exp_rxb = 8'h00;
        exp_ack = 1'b1;
    endtask

    task automatic test_write_ack();
        build_exp(1, 0, 1, 0, 0, 8'h81);
        run_cmd(1, 0, 1, 0, 0, 8'h81, 8'h00, 1'b0);
        exp_ack = 1'b0;
        n_chk++;
        if (first_diff() != -1)
            $display("FAIL wr81_ops diff at %0d got %0d ops want %0d",
                     first_diff(), log_q.size(), exp_q.size());
        else n_pass++;
        n_chk++;
        if (rx_ack !== exp_ack)
            $display("FAIL wr81_rx_ack got %b want %b", rx_ack, exp_ack);
        else n_pass++;
        n_chk++;
        if (n_done != 1 || n_err != 0)
            $display("FAIL wr81_done got done=%0d err=%0d want 1/0",
                     n_done, n_err);
        else n_pass++;
    endtask

    task automatic test_read_stop();
        build_exp(0, 1, 0, 1, 1, 8'h00);
        run_cmd(0, 1, 0, 1, 1, 8'h00, 8'hA5, 1'b0);
        exp_rxb = 8'hA5;
        n_chk++;
        if (first_diff() != -1)
            $display("FAIL rdA5_ops diff at %0d got %0d ops want %0d",
                     first_diff(), log_q.size(), exp_q.size());
        else n_pass++;
        n_chk++;
        if (rx_byte !== exp_rxb)
            $display("FAIL rdA5_rx_byte got %h want %h", rx_byte, exp_rxb);
        else n_pass++;
        n_chk++;
        if (rx_ack !== exp_ack)
            $display("FAIL rdA5_rx_ack_hold got %b want %b", rx_ack, exp_ack);
        else n_pass++;
        n_chk++;
        if (n_done != 1 || n_err != 0)
            $display("FAIL rdA5_done got done=%0d err=%0d want 1/0",
                     n_done, n_err);
        else n_pass++;
    endtask

    task automatic test_reject();
        int c0, bad;
        clear_mon();
        bad = 0;
        c0 = cyc_g;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_read = 1'b1;
        cmd_start = 1'b1; cmd_stop = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!cmd_ready || busy) bad++;
            tick();
        end
        n_chk++;
        if (n_err != 1 || err_cyc < 0 || err_cyc - c0 > 1)
            $display("FAIL reject_err got %0d pulses delay %0d want 1 <=1",
                     n_err, err_cyc - c0);
        else n_pass++;
        n_chk++;
        if (n_pulse != 0 || n_done != 0)
            $display("FAIL reject_phy got pulses=%0d done=%0d want 0/0",
                     n_pulse, n_done);
        else n_pass++;
        n_chk++;
        if (bad != 0)
            $display("FAIL reject_idle got %0d not-ready cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_random();
        bit s, p, w, r, a, ackr;
        int op;
        logic [7:0] tx, rb;
        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom); p = 1'($urandom);
            a = 1'($urandom); ackr = 1'($urandom);
            op = int'($urandom_range(0, 2));
            w = (op == 1); r = (op == 2);
            tx = 8'($urandom); rb = 8'($urandom);
            build_exp(s, p, w, r, a, tx);
            run_cmd(s, p, w, r, a, tx, rb, ackr);
            if (w) exp_ack = ackr;
            if (r) exp_rxb = rb;
            n_chk++;
            if (first_diff() != -1)
                $display("FAIL rnd%0d_ops diff at %0d got %0d ops want %0d",
                         k, first_diff(), log_q.size(), exp_q.size());
            else n_pass++;
            n_chk++;
            if (rx_byte !== exp_rxb)
                $display("FAIL rnd%0d_rx_byte got %h want %h",
                         k, rx_byte, exp_rxb);
            else n_pass++;
            n_chk++;
            if (rx_ack !== exp_ack)
                $display("FAIL rnd%0d_rx_ack got %b want %b",
                         k, rx_ack, exp_ack);
            else n_pass++;
            n_chk++;
            if (n_done != 1 || n_err != 0)
                $display("FAIL rnd%0d_done got done=%0d err=%0d want 1/0",
                         k, n_done, n_err);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        stuck_first_wr = 1'b1;
        run_cmd(1, 1, 1, 0, 0, 8'($urandom), 8'h00, 1'b0);
        stuck_first_wr = 1'b0;
        n_chk++;
        if (n_err != 1 || n_rel != 1 || n_done != 0)
            $display("FAIL tmo_abort got err=%0d rel=%0d done=%0d want 1/1/0",
                     n_err, n_rel, n_done);
        else n_pass++;
        n_chk++;
        if (err_cyc - first_wr_cyc < TMO || err_cyc - first_wr_cyc > TMO + 3)
            $display("FAIL tmo_delay got %0d cycles want %0d..%0d",
                     err_cyc - first_wr_cyc, TMO, TMO + 3);
        else n_pass++;
        n_chk++;
        if (log_q.size() != 2 || n_wr != 1)
            $display("FAIL tmo_ops got %0d ops %0d writes want 2/1",
                     log_q.size(), n_wr);
        else n_pass++;
        n_chk++;
        if (rx_ack !== exp_ack)
            $display("FAIL tmo_rx_ack got %b want %b", rx_ack, exp_ack);
        else n_pass++;
        model_idle();
        tick();
    endtask

    task automatic test_bus_drop();
        drop_at = 4;
        build_exp(0, 1, 1, 0, 0, 8'h5A);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        run_cmd(0, 1, 1, 0, 0, 8'h5A, 8'h00, 1'b0);
        drop_at = 0;
        bus_control_reg = 1'b1;
        n_chk++;
        if (first_diff() != -1)
            $display("FAIL drop_ops diff at %0d got %0d ops want %0d",
                     first_diff(), log_q.size(), exp_q.size());
        else n_pass++;
        n_chk++;
        if (n_err != 1 || n_rel != 1 || n_done != 0)
            $display("FAIL drop_abort got err=%0d rel=%0d done=%0d want 1/1/0",
                     n_err, n_rel, n_done);
        else n_pass++;
        model_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        int wc;
        logic [7:0] rb;
        clear_mon();
        rb = 8'($urandom);
        for (int i = 7; i >= 0; i--) rx_src.push_back(rb[i]);
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_write = 1'b0;
        cmd_start = 1'b0; cmd_stop = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wc = 0;
        while (n_rd < 5 && wc < 300) begin
            tick();
            wc++;
        end
        n_chk++;
        if (n_rd != 5)
            $display("FAIL rstmid_reach got %0d reads want 5", n_rd);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({cmd_ready, busy, done, err, rx_ack} !== 5'b10001 ||
            rx_byte !== 8'h00)
            $display("FAIL rstmid_ctrl got %b %h want 10001 00",
                     {cmd_ready, busy, done, err, rx_ack}, rx_byte);
        else n_pass++;
        n_chk++;
        if ({phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit,
             phy_release_bus, phy_tx_data} !== 6'b0)
            $display("FAIL rstmid_phy got %b want 000000",
                     {phy_start_bit, phy_stop_bit, phy_write_bit,
                      phy_read_bit, phy_release_bus, phy_tx_data});
        else n_pass++;
        model_idle();
        rx_src.delete();
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        n_chk++;
        if (n_pulse != 5 || n_rel != 0 || n_done != 0)
            $display("FAIL rstmid_quiet got pulses=%0d rel=%0d done=%0d want 5/0/0",
                     n_pulse, n_rel, n_done);
        else n_pass++;
        exp_rxb = 8'h00;
        exp_ack = 1'b0;
        build_exp(1, 1, 1, 0, 0, 8'h3C);
        run_cmd(1, 1, 1, 0, 0, 8'h3C, 8'h00, 1'b0);
        n_chk++;
        if (first_diff() != -1)
            $display("FAIL after_rst_ops diff at %0d got %0d ops want %0d",
                     first_diff(), log_q.size(), exp_q.size());
        else n_pass++;
        n_chk++;
        if (n_done != 1 || n_err != 0 || rx_ack !== exp_ack ||
            rx_byte !== exp_rxb)
            $display("FAIL after_rst_done got done=%0d err=%0d ack=%b rx=%h",
                     n_done, n_err, rx_ack, rx_byte);
        else n_pass++;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        n_chk = 0; n_pass = 0;
        n_multi = 0; n_unstable = 0; cyc_g = 0;
        mphase = 0; mhold = 0; mraise = 0;
        mread = 1'b0; mtx = 1'b0;
        phy_busy = 1'b0;
        test_reset();
        test_write_ack();
        test_read_stop();
        test_reject();
        test_random();
        test_timeout();
        test_bus_drop();
        test_reset_mid();
        n_chk++;
        if (n_multi != 0)
            $display("FAIL one_hot_pulses got %0d overlaps want 0", n_multi);
        else n_pass++;
        n_chk++;
        if (n_unstable != 0)
            $display("FAIL tx_stable got %0d changes want 0", n_unstable);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_byte_ctrl.md
I2C_BYTE_CTRL -- requirements
Module: i2c_byte_ctrl

Interface
REQ-001 The block SHALL have parameter BUSY_TIMEOUT, default 1023, giving the maximum cycles allowed in any wait for phy_busy before abort.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  byte command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_start  in  1  issue START before the byte.
- cmd_stop  in  1  issue STOP after the byte.
- cmd_write  in  1  write tx_byte, then read the ACK.
- cmd_read  in  1  read a byte, then send cmd_ack.
- cmd_ack  in  1  ACK bit value for a read (0=ACK, 1=NACK).
- tx_byte  in  8  data to write.
- rx_byte  out  8  received data.
- rx_ack  out  1  ACK bit sampled after a write.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.
- busy  out  1  command in progress.
- phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_release_bus  out  1 each  one-cycle PHY command pulses.
- phy_tx_data  out  1  bit to write.
- phy_busy  in  1  PHY executing a bit.
- phy_rx_data_reg  in  1  last bit read by the PHY.
- bus_control_reg  in  1  PHY holds the bus.

Function
REQ-003 Command acceptance SHALL occur only on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal 1 only in IDLE.
REQ-004 All cmd_* fields and tx_byte SHALL be latched at acceptance; later input changes SHALL have no effect on the command in progress.
REQ-005 A command with cmd_write=1 and cmd_read=1 SHALL be rejected: err pulses 1 cycle, no PHY pulse is issued, and the block stays in IDLE.
- Any other combination is legal, including all-zero (done pulses the next cycle).
REQ-006 Phase order SHALL be START (if cmd_start), then WRITE or READ, then STOP (if cmd_stop).
REQ-007 Every PHY bit operation SHALL follow ISSUE -> WAIT_HI -> WAIT_LO:
- ISSUE: one-cycle command pulse, issued only when phy_busy=0.
- WAIT_HI: wait for phy_busy=1.
- WAIT_LO: wait for phy_busy=0; the operation completes on the cycle phy_busy is seen 0.
REQ-008 WRITE SHALL issue 8 phy_write_bit operations, MSB first, with phy_tx_data held stable from ISSUE to completion.
- It SHALL then issue one phy_read_bit operation and latch rx_ack from phy_rx_data_reg at its completion.
REQ-009 READ SHALL issue 8 phy_read_bit operations, shifting phy_rx_data_reg into rx_byte MSB first at each completion.
- It SHALL then issue one phy_write_bit operation with phy_tx_data=cmd_ack.
REQ-010 A 3-bit counter SHALL track bit index 7..0; wrap from 0 SHALL move to the ACK phase.
REQ-011 States SHALL be IDLE, START, WRITE, WRITE_ACK, READ, READ_ACK, STOP, DONE, ABORT.
REQ-012 DONE SHALL pulse done for one cycle and return to IDLE; rx_byte and rx_ack SHALL hold their values until the next command updates them.
REQ-013 A timeout counter SHALL reset on each ISSUE; reaching BUSY_TIMEOUT cycles in WAIT_HI or WAIT_LO SHALL enter ABORT.
REQ-014 Outside START and IDLE, bus_control_reg=0 at any WAIT_LO completion SHALL enter ABORT.
REQ-015 ABORT SHALL pulse phy_release_bus and err for one cycle, omit done, and return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 At most one phy_* command pulse SHALL be high in any cycle.

Reset
REQ-018 While rst=0, the block SHALL hold the following values, asynchronously:
- state=IDLE, cmd_ready=1, busy=0, done=0, err=0;
- rx_byte=8'h00, rx_ack=1;
- all phy_* outputs=0, counters=0.
REQ-019 Reset mid-command SHALL drop the operation immediately, with no STOP or release pulse; the first command after reset SHALL be accepted normally.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- start+write 0x81, PHY model ACKs -> 1 start pulse; 8 write pulses with tx bits 1,0,0,0,0,0,0,1; 1 read pulse; rx_ack=0; done pulse.
- read+stop, cmd_ack=1, model returns 0xA5 -> rx_byte=0xA5; ninth write pulse has phy_tx_data=1; one stop pulse; done.
- cmd_write=cmd_read=1 -> err pulse within 1 cycle, zero PHY pulses, cmd_ready stays 1.
- phy_busy stuck 1 after the first write with BUSY_TIMEOUT=15 -> err and phy_release_bus pulse after 15 wait cycles, no done.
- bus_control_reg dropped at bit 4 of a write -> abort with err, remaining bits not issued.
- rst=0 asserted at bit 3 of a read -> all outputs at reset values the same cycle; next write 0x3C completes correctly.
